// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types for the memory responder
`include "system_defines.svh"

package mem_pkg;

  localparam int XLEN = `XLEN;
  localparam int BE_W = `BYTEENABLE_WIDTH;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } mem_state_e;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] writedata;
    logic [BE_W-1:0] byteenable;
    logic            is_write;
  } mem_req_t;

endpackage

// File: rtl/mod_mem_ram.sv
// rtl/mod_mem_ram.sv - single-port synchronous byte-enabled backing store
module mod_mem_ram
  import mem_pkg::*;
#(
  parameter int unsigned WORDS = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic            clk_i,
  input  logic            en_i,
  input  logic            we_i,
  input  logic [BE_W-1:0] be_i,
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic [XLEN-1:0] rdata_o
);

  logic [XLEN-1:0] mem_q [WORDS];

  // rdata_o only moves on a read, so it holds across writes and idle cycles
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        for (int i = 0; i < BE_W; i++) begin
          if (be_i[i]) begin
            mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
          end
        end
      end else begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/system_defines.svh
// rtl/system_defines.svh - system-wide bus widths
`ifndef SYSTEM_DEFINES_SVH
`define SYSTEM_DEFINES_SVH

`define XLEN 32
`define BYTEENABLE_WIDTH 4

`endif

// File: rtl/mod_mem_responder.sv
// rtl/mod_mem_responder.sv - fixed-latency memory responder with strobe handshake
module mod_mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned     MEM_WORDS = 1024,
  parameter int unsigned     LATENCY   = 3,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] memory_address_i,
  input  logic [XLEN-1:0] memory_writedata_i,
  input  logic [BE_W-1:0] memory_byteenable_i,
  input  logic            memory_read_i,
  input  logic            memory_write_i,
  output logic [XLEN-1:0] memory_readdata_o,
  output logic            memory_operation_stb_o,
  output logic            memory_error_o
);

  localparam int unsigned AW       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  CNT_LOAD = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

  mem_state_e state_q;
  mem_req_t   req_q;
  logic [3:0] cnt_q;
  logic       stb_q;
  logic       err_q;
  logic       rd_valid_q;

  logic            accept;
  logic            enter_resp;
  logic            cur_write;
  logic            cur_in_range;
  logic [XLEN-1:0] cur_addr;
  logic [XLEN-1:0] cur_offset;
  logic [AW-1:0]   ram_addr;
  logic [XLEN-1:0] ram_rdata;
  logic            ram_en;
  logic            ram_we;

  // In IDLE the live bus is the active request so LATENCY==1 can read the RAM on the accept edge
  always_comb begin
    accept       = (state_q == IDLE) && (memory_read_i || memory_write_i);
    enter_resp   = (accept && (LATENCY == 1)) || ((state_q == WAIT) && (cnt_q == '0));
    cur_addr     = (state_q == IDLE) ? memory_address_i : req_q.address;
    cur_write    = (state_q == IDLE) ? memory_write_i : req_q.is_write;
    cur_offset   = cur_addr - BASE_ADDR;
    cur_in_range = (cur_addr >= BASE_ADDR) && ((cur_offset >> 2) < XLEN'(MEM_WORDS));
    ram_addr     = cur_offset[AW+1:2];
    ram_we       = (state_q == RESP) && req_q.is_write && cur_in_range;
    ram_en       = ram_we || (enter_resp && !cur_write && cur_in_range);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      req_q      <= '0;
      cnt_q      <= '0;
      stb_q      <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      stb_q <= enter_resp;
      err_q <= enter_resp && !cur_in_range;
      if (enter_resp && !cur_write) begin
        rd_valid_q <= cur_in_range;
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            req_q.address    <= memory_address_i;
            req_q.writedata  <= memory_writedata_i;
            req_q.byteenable <= memory_byteenable_i;
            req_q.is_write   <= memory_write_i;
            cnt_q            <= CNT_LOAD;
            state_q          <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: state_q <= HOLD;
        HOLD: begin
          if (!memory_read_i && !memory_write_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  mod_mem_ram #(
    .WORDS (MEM_WORDS),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .en_i    (ram_en),
    .we_i    (ram_we),
    .be_i    (req_q.byteenable),
    .addr_i  (ram_addr),
    .wdata_i (req_q.writedata),
    .rdata_o (ram_rdata)
  );

  // Out-of-range reads and reset both present zero without touching the RAM output register
  assign memory_readdata_o      = rd_valid_q ? ram_rdata : '0;
  assign memory_operation_stb_o = stb_q;
  assign memory_error_o         = err_q;

endmodule
